mp_addsub_seq: RTL
==================

MP_ADDSUB_SEQ -- requirements
Module: mp_addsub_seq

Interface
- REQ-001 The block SHALL have parameter DATA_SIZE, default 8: width of the single internal add/subtract word slice.
- REQ-002 The block SHALL have parameter NUM_WORDS, default 4, minimum 1: number of words per operand. Define W = DATA_SIZE*NUM_WORDS.
- REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-005 The block SHALL have port in_valid, input, 1 bit: operation request.
- REQ-006 The block SHALL have port in_ready, output, 1 bit: request accepted when in_valid and in_ready are both high at a rising edge.
- REQ-007 The block SHALL have ports a_in and b_in, input, W bits each: unsigned operands, word 0 = bits [DATA_SIZE-1:0].
- REQ-008 The block SHALL have port operation, input, 1 bit: 1 = addition, 0 = subtraction (a - b).
- REQ-009 The block SHALL have port cin, input, 1 bit: carry-in to word 0, used for addition only.
- REQ-010 The block SHALL have ports out_valid, output, 1 bit, and out_ready, input, 1 bit: result handshake.
- REQ-011 The block SHALL have port result, output, W bits: sum or difference.
- REQ-012 The block SHALL have ports cout, zero and ovf, output, 1 bit each: final carry, result==0, and signed two's-complement overflow.

Function
- REQ-013 The block SHALL implement a 3-state FSM with states IDLE, RUN and DONE.
- REQ-014 In IDLE, in_ready SHALL be 1 and out_valid 0; in RUN, both SHALL be 0; in DONE, in_ready SHALL be 0 and out_valid 1.
- REQ-015 On acceptance (edge E0) the block SHALL latch a_in, b_in, operation and cin, clear the word index to 0, and go to RUN.
- REQ-016 Each RUN cycle SHALL process exactly one word i through the single DATA_SIZE-bit slice, in order i = 0 .. NUM_WORDS-1.
- REQ-017 The word-i operation SHALL be: add = a_i + b_i + c_i; subtract = a_i + ~b_i + c_i.
- REQ-018 The word-0 carry c_0 SHALL be cin for addition and 1 for subtraction; cin SHALL be ignored for subtraction.
- REQ-019 The carry-out of word i SHALL be registered as c_(i+1) for the next RUN cycle.
- REQ-020 The result of word i SHALL be written to result word i at edge E(i+1).
- REQ-021 At edge E(NUM_WORDS), the FSM SHALL go to DONE; the result SHALL therefore be visible NUM_WORDS cycles after acceptance.
- REQ-022 cout SHALL equal the carry out of word NUM_WORDS-1; for subtraction, cout=1 means no borrow (a >= b) and cout=0 means borrow.
- REQ-023 zero SHALL be 1 if and only if all W result bits are 0.
- REQ-024 ovf SHALL be (sign(a) == sign(b')) && (sign(result) != sign(a)), where b' = b for addition and ~b for subtraction.
- REQ-025 cout, zero and ovf SHALL be valid whenever out_valid=1.
- REQ-026 In DONE with out_ready=1 at an edge, the FSM SHALL go to IDLE.
- REQ-027 In DONE with out_ready=0, the FSM SHALL hold DONE with result and all flags stable.
- REQ-028 in_valid SHALL be ignored outside IDLE; latched operands SHALL NOT change until the next acceptance.
- REQ-029 The minimum period between acceptances SHALL be NUM_WORDS+2 cycles: RUN, DONE, then IDLE for one cycle.
- REQ-030 Carry out of the top word SHALL be reported only via cout; result SHALL wrap modulo 2^W.
- REQ-031 With NUM_WORDS=1, the block SHALL spend a single RUN cycle and behave identically otherwise.

Reset
- REQ-032 With rst=1 at an edge, the block SHALL enter IDLE from any state, including mid-RUN, and abandon any operation in progress.
- REQ-033 Reset SHALL clear result, cout, zero, ovf, the word index and the carry register to 0; in the cycle after the reset edge, in_ready=1 and out_valid=0.
- REQ-034 rst SHALL have priority over in_valid and out_ready in the same cycle.

Verification (DATA_SIZE=8, NUM_WORDS=4)
- REQ-035 The bench SHALL apply add 0x000000FF + 0x00000001, cin=0 -> result=0x00000100, cout=0, zero=0, ovf=0, out_valid high 4 cycles after acceptance.
- REQ-036 The bench SHALL apply add 0xFFFFFFFF + 0x00000001, cin=0 -> result=0x00000000, cout=1, zero=1, ovf=0.
- REQ-037 The bench SHALL apply sub 0x00000005 - 0x00000007, cin=1 -> result=0xFFFFFFFE, cout=0, ovf=0, showing cin is ignored.
- REQ-038 The bench SHALL apply add 0x7FFFFFFF + 0x00000001 -> result=0x80000000, ovf=1, cout=0.
- REQ-039 The bench SHALL hold out_ready=0 for 3 cycles in DONE while driving a new in_valid -> result and flags stable, in_ready=0, new request not accepted; then raise out_ready -> IDLE, then the new request is accepted.
- REQ-040 The bench SHALL assert rst during the second RUN cycle -> next cycle: in_ready=1, out_valid=0, result=0; a following add 2+3 -> result=0x00000005.

Source files
------------

// File: rtl/mp_addsub_seq.sv
// mp_addsub_seq: multi-precision add/subtract.
// One DATA_SIZE-bit slice handles one word per cycle, starting with the
// least significant word. The carry is kept in a register between words.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   in_valid        operation request (input)
//   in_ready        request accepted (output)
//   a_in, b_in      W-bit unsigned operands; word 0 is bits [DATA_SIZE-1:0]
//   operation       1 = a + b + cin, 0 = a - b (cin ignored)
//   cin             carry into word 0, used for addition only
//   out_valid       result available (output)
//   out_ready       result consumed (input)
//   result          W-bit sum/difference, wraps modulo 2^W
//   cout            carry out of the top word (subtract: 1 = no borrow)
//   zero            result == 0
//   ovf             signed two's-complement overflow
//   fsm_state       debug view of the FSM: 0 IDLE, 1 RUN, 2 DONE
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE and out_valid only in DONE.
// result and flags hold steady while out_valid is high and out_ready is low.
module mp_addsub_seq #(
  parameter int DATA_SIZE = 8,
  parameter int NUM_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_SIZE*NUM_WORDS-1:0] a_in,
  input  logic [DATA_SIZE*NUM_WORDS-1:0] b_in,
  input  logic                           operation,
  input  logic                           cin,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_SIZE*NUM_WORDS-1:0] result,
  output logic                           cout,
  output logic                           zero,
  output logic                           ovf,
  output logic [1:0]                     fsm_state
);

  localparam int W     = DATA_SIZE * NUM_WORDS;
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic               op_q;
  logic [IDX_W-1:0]   idx;
  logic               carry;

  logic [DATA_SIZE-1:0] a_w;
  logic [DATA_SIZE-1:0] b_w;
  logic [DATA_SIZE-1:0] b_eff;
  logic [DATA_SIZE:0]   sum;
  logic [W-1:0]         res_next;
  logic                 last_word;

  assign fsm_state = state;
  assign last_word = (idx == IDX_W'(NUM_WORDS - 1));

  // Word slice: pick word idx, add, and merge the slice result back into
  // a copy of the result register.
  always_comb begin
    a_w      = '0;
    b_w      = '0;
    res_next = result;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (idx == IDX_W'(k)) begin
        a_w = a_q[k*DATA_SIZE +: DATA_SIZE];
        b_w = b_q[k*DATA_SIZE +: DATA_SIZE];
      end
    end
    // Subtraction is a + ~b + 1; the +1 comes from the initial carry.
    b_eff = op_q ? b_w : ~b_w;
    sum   = {1'b0, a_w} + {1'b0, b_eff} + {{DATA_SIZE{1'b0}}, carry};
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (idx == IDX_W'(k)) begin
        res_next[k*DATA_SIZE +: DATA_SIZE] = sum[DATA_SIZE-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a_in;
            b_q      <= b_in;
            op_q     <= operation;
            idx      <= '0;
            carry    <= operation ? cin : 1'b1;
            state    <= RUN;
            in_ready <= 1'b0;
          end
        end
        RUN: begin
          result <= res_next;
          carry  <= sum[DATA_SIZE];
          if (last_word) begin
            // On the top word a_w holds sign(a) and b_eff holds sign(b').
            cout      <= sum[DATA_SIZE];
            zero      <= (res_next == '0);
            ovf       <= (a_w[DATA_SIZE-1] == b_eff[DATA_SIZE-1]) &&
                         (sum[DATA_SIZE-1] != a_w[DATA_SIZE-1]);
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
